// File: rtl/beamformer_pkg.sv
// Shared defaults, sequencer state encoding and the output saturation helper.
package beamformer_pkg;

  localparam int NUMBER_OF_BITS_DEF = 8;
  localparam int BUFFER_SIZE_DEF    = 16;

  typedef enum logic [1:0] {IDLE, COMMIT, READ, EMIT} state_e;

  // Clamp a sign-extended accumulator to the signed nbits range.
  function automatic logic signed [31:0] sat(input logic signed [31:0] v,
                                             input int nbits);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (nbits - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/delay_shadow_regs.sv
// Shadow/active delay banks: writes land in shadow, commit copies shadow to
// active in one cycle, and the read port muxes one active entry.
module delay_shadow_regs #(
  parameter int NUM_CHANNELS = 3,
  parameter int IDX_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [2:0]       wr_channel,
  input  logic [IDX_W-1:0] wr_delay,
  input  logic             commit,
  input  logic [2:0]       rd_sel,
  output logic [IDX_W-1:0] rd_delay
);

  logic [NUM_CHANNELS-1:0][IDX_W-1:0] shadow_q, active_q;

  // Bank update; commit reads the pre-edge shadow, so a same-cycle write
  // only becomes visible at the following commit. Out-of-range channels
  // match no entry and are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (wr_en && (wr_channel == 3'(i))) shadow_q[i] <= wr_delay;
      end
      if (commit) active_q <= shadow_q;
    end
  end

  // Indexed read of the committed bank.
  always_comb begin
    rd_delay = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      if ({1'b0, rd_sel} == 4'(i)) rd_delay = active_q[i];
    end
  end

endmodule

// File: rtl/beamform_sequencer.sv
// Frame-synchronous beamformer sequencer: commit delays, read each channel
// at its delay index, accumulate, saturate and emit one beam sample.
module beamform_sequencer
  import beamformer_pkg::*;
#(
  parameter int NUM_CHANNELS   = 3,
  parameter int NUMBER_OF_BITS = NUMBER_OF_BITS_DEF,
  parameter int BUFFER_SIZE    = BUFFER_SIZE_DEF,
  localparam int IDX_W         = $clog2(BUFFER_SIZE)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_start,
  input  logic                      cfg_valid,
  input  logic [2:0]                cfg_channel,
  input  logic [IDX_W-1:0]          cfg_delay,
  output logic [2:0]                rd_channel,
  output logic [IDX_W-1:0]          rd_index,
  input  logic [NUMBER_OF_BITS-1:0] rd_data,
  output logic [NUMBER_OF_BITS-1:0] out_sample,
  output logic                      out_valid,
  output logic                      busy,
  output logic                      overrun,
  output logic                      cfg_error
);

  localparam int         ACC_W   = NUMBER_OF_BITS + $clog2(NUM_CHANNELS) + 1;
  localparam logic [2:0] LAST_CH = 3'(NUM_CHANNELS - 1);
  localparam logic [3:0] NCH     = 4'(NUM_CHANNELS);

  state_e                   state_q, state_d;
  logic [2:0]               ch_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  rd_ext;
  logic                     commit;
  logic [2:0]               rd_sel;
  logic                     cfg_bad;

  assign cfg_bad    = cfg_valid && ({1'b0, cfg_channel} >= NCH);
  assign rd_ext     = {{(ACC_W-NUMBER_OF_BITS){rd_data[NUMBER_OF_BITS-1]}}, rd_data};
  assign rd_channel = rd_sel;

  delay_shadow_regs #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .IDX_W        (IDX_W)
  ) u_regs (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (cfg_valid),
    .wr_channel (cfg_channel),
    .wr_delay   (cfg_delay),
    .commit     (commit),
    .rd_sel     (rd_sel),
    .rd_delay   (rd_index)
  );

  // Next-state and per-state strobes; read port parks on channel 0.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    rd_sel  = 3'd0;
    case (state_q)
      IDLE:   if (frame_start) state_d = COMMIT;
      COMMIT: begin
        commit  = 1'b1;
        state_d = READ;
      end
      READ: begin
        rd_sel = ch_q;
        if (ch_q == LAST_CH) state_d = EMIT;
      end
      EMIT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Channel walk and sign-extended accumulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      ch_q  <= '0;
    end else if (state_q == COMMIT) begin
      acc_q <= '0;
      ch_q  <= '0;
    end else if (state_q == READ) begin
      acc_q <= acc_q + rd_ext;
      ch_q  <= ch_q + 3'd1;
    end
  end

  // Registered sample, strobe and busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_sample <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      busy      <= (state_d != IDLE);
      if (state_q == EMIT) begin
        out_sample <= NUMBER_OF_BITS'(sat({{(32-ACC_W){acc_q[ACC_W-1]}}, acc_q},
                                          NUMBER_OF_BITS));
        out_valid  <= 1'b1;
      end
    end
  end

  // Sticky error flags; a frame_start on the EMIT->IDLE edge counts as overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun   <= 1'b0;
      cfg_error <= 1'b0;
    end else begin
      if (frame_start && (state_q != IDLE)) overrun   <= 1'b1;
      if (cfg_bad)                          cfg_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_beamform_sequencer.sv
// Scoreboard bench: stimulus updates a frame-level model and queues expected
// beam samples; a negedge monitor checks outputs and flags independently.
module tb_beamform_sequencer;

  localparam int N  = 3;
  localparam int NB = 8;
  localparam int BS = 16;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_start, cfg_valid;
  logic [2:0]    cfg_channel;
  logic [IW-1:0] cfg_delay;
  logic [2:0]    rd_channel;
  logic [IW-1:0] rd_index;
  logic [NB-1:0] rd_data;
  logic [NB-1:0] out_sample;
  logic          out_valid, busy, overrun, cfg_error;

  beamform_sequencer #(.NUM_CHANNELS(N), .NUMBER_OF_BITS(NB), .BUFFER_SIZE(BS)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .cfg_valid(cfg_valid),
    .cfg_channel(cfg_channel), .cfg_delay(cfg_delay), .rd_channel(rd_channel),
    .rd_index(rd_index), .rd_data(rd_data), .out_sample(out_sample),
    .out_valid(out_valid), .busy(busy), .overrun(overrun), .cfg_error(cfg_error)
  );

  always #5 clk = ~clk;

  // Channel buffers modelled as a combinational lookup.
  logic signed [NB-1:0] mem [0:7][0:BS-1];
  assign rd_data = mem[rd_channel][rd_index];

  // Reference model state.
  typedef struct { int sample; int cyc; } exp_t;
  exp_t sbq[$];
  int   m_shadow [N];
  int   m_active [N];
  bit   m_ovr, m_cerr, have_start;
  int   cyc, next_free, commit_edge, start_edge;
  int   errors = 0, checks = 0;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int sat_ref(input int s);
    int hi, lo;
    hi = (1 << (NB - 1)) - 1;
    lo = -(1 << (NB - 1));
    return (s > hi) ? hi : (s < lo) ? lo : s;
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < N; c++) begin
      m_shadow[c] = 0;
      m_active[c] = 0;
    end
    m_ovr = 0; m_cerr = 0; have_start = 0;
    next_free = 0; commit_edge = -1; start_edge = 0;
    sbq.delete();
  endfunction

  // One clock edge of stimulus; called at a negedge, returns at the next one.
  task automatic step(input bit fs, input bit cv, input int cch, input int cdl);
    int k, s;
    frame_start = fs;
    cfg_valid   = cv;
    cfg_channel = 3'(cch);
    cfg_delay   = IW'(cdl);
    @(posedge clk);
    k = cyc;
    if (commit_edge == k) begin
      s = 0;
      for (int c = 0; c < N; c++) begin
        m_active[c] = m_shadow[c];
        s += int'(mem[c][m_active[c]]);
      end
      sbq.push_back('{sat_ref(s), start_edge + N + 3});
      commit_edge = -1;
    end
    if (cv) begin
      if (cch < N) m_shadow[cch] = cdl;
      else         m_cerr = 1;
    end
    if (fs) begin
      if (k >= next_free) begin
        start_edge  = k;
        have_start  = 1;
        commit_edge = k + 1;
        next_free   = k + N + 3;
      end else m_ovr = 1;
    end
    cyc = k + 1;
    @(negedge clk);
    frame_start = 1'b0;
    cfg_valid   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_out_sample", $signed(out_sample), 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_cfg_error", cfg_error, 0);
    chk("rst_rd_channel", rd_channel, 0);
    chk("rst_rd_index", rd_index, 0);
    model_clear();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic clear_mem();
    for (int c = 0; c < 8; c++)
      for (int i = 0; i < BS; i++) mem[c][i] = '0;
  endtask

  // Monitor: compare emitted samples against the queue, plus status flags.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (sbq.size() != 0 && cyc > sbq[0].cyc) begin
        e = sbq.pop_front();
        checks++; errors++;
        $display("FAIL missing_out_valid: expected sample %0d at cycle %0d, out_valid stayed low",
                 e.sample, e.cyc);
      end
      if (out_valid) begin
        if (sbq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out_valid: got sample %0d, expected no output (cycle %0d)",
                   $signed(out_sample), cyc);
        end else begin
          e = sbq.pop_front();
          chk("out_sample", $signed(out_sample), e.sample);
          chk("out_latency", cyc, e.cyc);
        end
      end
      chk("busy", busy, (have_start && cyc >= start_edge + 1 && cyc <= start_edge + N + 2) ? 1 : 0);
      chk("overrun", overrun, m_ovr);
      chk("cfg_error", cfg_error, m_cerr);
    end
  end

  initial begin
    reset = 1'b1; frame_start = 1'b0; cfg_valid = 1'b0;
    cfg_channel = '0; cfg_delay = '0; cyc = 0;
    clear_mem();
    model_clear();
    @(negedge clk);
    do_reset();

    // Basic frame: delays 2,5,7 and data 10,20,30 -> 60 in cycle 6.
    step(0, 1, 0, 2); step(0, 1, 1, 5); step(0, 1, 2, 7);
    mem[0][2] = 8'sd10; mem[1][5] = 8'sd20; mem[2][7] = 8'sd30;
    step(1, 0, 0, 0);
    step(0, 0, 0, 0); chk("rd_index_c2", rd_index, 2); chk("rd_channel_c2", rd_channel, 0);
    step(0, 0, 0, 0); chk("rd_index_c3", rd_index, 5); chk("rd_channel_c3", rd_channel, 1);
    step(0, 0, 0, 0); chk("rd_index_c4", rd_index, 7); chk("rd_channel_c4", rd_channel, 2);
    idle(4);

    // Positive and negative saturation.
    mem[0][2] = 8'sd100; mem[1][5] = 8'sd100; mem[2][7] = 8'sd100;
    step(1, 0, 0, 0); idle(N + 3);
    mem[0][2] = -8'sd128; mem[1][5] = -8'sd128; mem[2][7] = -8'sd128;
    step(1, 0, 0, 0); idle(N + 3);

    // Write on the commit edge lands in the next frame only.
    mem[0][2] = 8'sd1; mem[1][5] = 8'sd2; mem[2][7] = 8'sd3; mem[1][9] = 8'sd50;
    step(1, 0, 0, 0); step(0, 1, 1, 9); idle(N + 2);
    step(1, 0, 0, 0); idle(N + 3);

    // Overrun mid-frame, then invalid channel write leaves shadow alone.
    step(1, 0, 0, 0); idle(2); step(1, 0, 0, 0); idle(N);
    chk("overrun_set", overrun, 1);
    step(0, 1, 5, 3); chk("cfg_error_set", cfg_error, 1);
    step(1, 0, 0, 0); idle(N + 3);

    // frame_start on the EMIT->IDLE edge is an overrun and starts nothing.
    do_reset();
    step(1, 0, 0, 0); idle(N + 1); step(1, 0, 0, 0);
    chk("overrun_emit_edge", overrun, 1);
    idle(N + 4);

    // Reset in cycle 3 aborts; next frame runs with delays 0.
    do_reset();
    step(0, 1, 0, 2); step(0, 1, 1, 5); step(0, 1, 2, 7);
    mem[0][0] = 8'sd7; mem[1][0] = -8'sd3; mem[2][0] = 8'sd11;
    step(1, 0, 0, 0); idle(2);
    do_reset();
    idle(N + 4);
    step(1, 0, 0, 0); idle(N + 3);

    // Randomized frames with stray writes, invalid channels and overruns.
    for (int it = 0; it < 40; it++) begin
      for (int c = 0; c < 8; c++)
        for (int i = 0; i < BS; i++) mem[c][i] = NB'($urandom);
      repeat ($urandom_range(0, 3))
        step(0, 1, ($urandom_range(0, 9) == 0) ? $urandom_range(N, 7) : $urandom_range(0, N - 1),
             $urandom_range(0, BS - 1));
      step(1, $urandom_range(0, 1), $urandom_range(0, N - 1), $urandom_range(0, BS - 1));
      for (int j = 0; j < N + 2; j++)
        step($urandom_range(0, 9) == 0, $urandom_range(0, 1),
             ($urandom_range(0, 9) == 0) ? $urandom_range(N, 7) : $urandom_range(0, N - 1),
             $urandom_range(0, BS - 1));
      idle($urandom_range(0, 2));
    end

    idle(2);
    chk("pending_outputs", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
